// File: rtl/ahbl_pkg.sv
// Shared AHB-Lite encodings for the two-master arbiter: HTRANS values and
// data-phase owner encoding.
package ahbl_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_M0   = 2'd1,
    OWN_M1   = 2'd2
  } own_e;

  function automatic logic is_active(input logic [1:0] htrans);
    return (htrans == HTRANS_NONSEQ) || (htrans == HTRANS_SEQ);
  endfunction

endpackage

// File: rtl/ahbl_arb_hold.sv
// Per-master hold register: keeps a losing address phase and selects it over
// the live master signals until the arbiter grants it.
module ahbl_arb_hold (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        capture_i,
  input  logic        clear_i,
  input  logic [31:0] haddr_i,
  input  logic [2:0]  hsize_i,
  input  logic        hwrite_i,
  output logic        pend_o,
  output logic [31:0] haddr_o,
  output logic [2:0]  hsize_o,
  output logic        hwrite_o
);

  logic        pend_q, pend_d;
  logic [31:0] addr_q, addr_d;
  logic [2:0]  size_q, size_d;
  logic        write_q, write_d;

  always_comb begin
    pend_d  = pend_q;
    addr_d  = addr_q;
    size_d  = size_q;
    write_d = write_q;
    if (clear_i) begin
      pend_d = 1'b0;
    end else if (capture_i) begin
      pend_d  = 1'b1;
      addr_d  = haddr_i;
      size_d  = hsize_i;
      write_d = hwrite_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q  <= 1'b0;
      addr_q  <= 32'h0;
      size_q  <= 3'h0;
      write_q <= 1'b0;
    end else begin
      pend_q  <= pend_d;
      addr_q  <= addr_d;
      size_q  <= size_d;
      write_q <= write_d;
    end
  end

  assign pend_o   = pend_q;
  assign haddr_o  = pend_q ? addr_q  : haddr_i;
  assign hsize_o  = pend_q ? size_q  : hsize_i;
  assign hwrite_o = pend_q ? write_q : hwrite_i;

endmodule

// File: rtl/ahbl_arbiter2.sv
// Two-master AHB-Lite arbiter with per-master address hold and HREADY stretch.
// Define AHBL_ARB_RR_EN for round-robin tie breaking; otherwise fixed priority.
module ahbl_arbiter2
  import ahbl_pkg::*;
#(
  parameter logic HI_PRIO = 1'b0
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic [31:0] M0_HADDR,
  input  logic [1:0]  M0_HTRANS,
  input  logic [2:0]  M0_HSIZE,
  input  logic        M0_HWRITE,
  input  logic [31:0] M0_HWDATA,
  output logic        M0_HREADY,
  output logic [31:0] M0_HRDATA,
  input  logic [31:0] M1_HADDR,
  input  logic [1:0]  M1_HTRANS,
  input  logic [2:0]  M1_HSIZE,
  input  logic        M1_HWRITE,
  input  logic [31:0] M1_HWDATA,
  output logic        M1_HREADY,
  output logic [31:0] M1_HRDATA,
  output logic [31:0] HADDR,
  output logic [1:0]  HTRANS,
  output logic [2:0]  HSIZE,
  output logic        HWRITE,
  output logic [31:0] HWDATA,
  input  logic        HREADY,
  input  logic [31:0] HRDATA
);

  own_e        dp_own_q, dp_own_d;
  logic        pend0, pend1, live0, live1, req0, req1, gnt0, gnt1, tie_pick1;
  logic [31:0] h0_addr, h1_addr;
  logic [2:0]  h0_size, h1_size;
  logic        h0_write, h1_write;

  // A waiting master sees HREADY low until its held transfer finishes on the bus.
  assign M0_HREADY = (dp_own_q == OWN_M0) ? HREADY : ~pend0;
  assign M1_HREADY = (dp_own_q == OWN_M1) ? HREADY : ~pend1;

  assign live0 = is_active(M0_HTRANS) & M0_HREADY & ~pend0;
  assign live1 = is_active(M1_HTRANS) & M1_HREADY & ~pend1;
  assign req0  = pend0 | live0;
  assign req1  = pend1 | live1;

`ifdef AHBL_ARB_RR_EN
  logic rr_last_q, rr_last_d;

  assign tie_pick1 = ~rr_last_q;

  always_comb begin
    rr_last_d = rr_last_q;
    if (gnt0)      rr_last_d = 1'b0;
    else if (gnt1) rr_last_d = 1'b1;
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) rr_last_q <= ~HI_PRIO;
    else          rr_last_q <= rr_last_d;
  end
`else
  assign tie_pick1 = HI_PRIO;
`endif

  // Grants only in free address slots; reset also blocks forwarding of live requests.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (HREADY && HRESETn) begin
      if (req0 && req1) begin
        gnt1 = tie_pick1;
        gnt0 = ~tie_pick1;
      end else begin
        gnt0 = req0;
        gnt1 = req1;
      end
    end
  end

  always_comb begin
    dp_own_d = dp_own_q;
    if (HREADY) begin
      if (gnt0)      dp_own_d = OWN_M0;
      else if (gnt1) dp_own_d = OWN_M1;
      else           dp_own_d = OWN_NONE;
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) dp_own_q <= OWN_NONE;
    else          dp_own_q <= dp_own_d;
  end

  ahbl_arb_hold u_hold0 (
    .clk(HCLK), .rst_n(HRESETn), .capture_i(live0 & ~gnt0), .clear_i(gnt0),
    .haddr_i(M0_HADDR), .hsize_i(M0_HSIZE), .hwrite_i(M0_HWRITE),
    .pend_o(pend0), .haddr_o(h0_addr), .hsize_o(h0_size), .hwrite_o(h0_write)
  );

  ahbl_arb_hold u_hold1 (
    .clk(HCLK), .rst_n(HRESETn), .capture_i(live1 & ~gnt1), .clear_i(gnt1),
    .haddr_i(M1_HADDR), .hsize_i(M1_HSIZE), .hwrite_i(M1_HWRITE),
    .pend_o(pend1), .haddr_o(h1_addr), .hsize_o(h1_size), .hwrite_o(h1_write)
  );

  always_comb begin
    HTRANS = HTRANS_IDLE;
    HADDR  = M0_HADDR;
    HSIZE  = M0_HSIZE;
    HWRITE = M0_HWRITE;
    if (gnt1) begin
      HTRANS = HTRANS_NONSEQ;
      HADDR  = h1_addr;
      HSIZE  = h1_size;
      HWRITE = h1_write;
    end else if (gnt0) begin
      HTRANS = HTRANS_NONSEQ;
      HADDR  = h0_addr;
      HSIZE  = h0_size;
      HWRITE = h0_write;
    end
  end

  always_comb begin
    HWDATA = 32'h0;
    case (dp_own_q)
      OWN_M0:  HWDATA = M0_HWDATA;
      OWN_M1:  HWDATA = M1_HWDATA;
      default: HWDATA = 32'h0;
    endcase
  end

  assign M0_HRDATA = HRDATA;
  assign M1_HRDATA = HRDATA;

endmodule
